// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor on the free-running reference clock: pulses the PLL reset,
// filters the synchronized lock flag and releases a clean core reset plus ready flag.
//   state       | meaning
//   S_PLL_RST   | PLL reset held high for PLL_RST_PULSE cycles
//   S_WAIT_LOCK | waiting for locked_s, timeout running
//   S_FILTER    | counting consecutive high locked_s cycles, timeout running
//   S_HOLD      | lock qualified, core reset held RESET_HOLD more cycles
//   S_RUN       | core released, ready asserted
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int PLL_RST_PULSE = 16,
    parameter int LOCK_FILTER   = 1024,
    parameter int RESET_HOLD    = 256,
    parameter int LOCK_TIMEOUT  = 2500000,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic [CNT_W-1:0] relock_count
);

    localparam int PW = (PLL_RST_PULSE > 1) ? $clog2(PLL_RST_PULSE) : 1;
    localparam int FW = (LOCK_FILTER   > 1) ? $clog2(LOCK_FILTER)   : 1;
    localparam int HW = (RESET_HOLD    > 1) ? $clog2(RESET_HOLD)    : 1;
    localparam int TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(PLL_RST_PULSE - 1);
    localparam logic [FW-1:0] FLT_LAST   = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [PW-1:0]           pulse_q, pulse_d;
    logic [FW-1:0]           flt_q, flt_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [CNT_W-1:0]        relock_q, relock_d;
    logic                    pll_rst_q, pll_rst_d;
    logic                    sys_reset_q, sys_reset_d;
    logic                    ready_q, ready_d;
    logic                    locked_s;
    logic                    timeout;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
    assign locked_s = sync_q[SYNC_STAGES-1];
    assign timeout  = (tmo_q == TMO_LAST);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PLL_RST;
            sync_q      <= '0;
            pulse_q     <= '0;
            flt_q       <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            relock_q    <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            pulse_q     <= pulse_d;
            flt_q       <= flt_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            relock_q    <= relock_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        flt_d    = flt_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;
        relock_d = relock_q;
        case (state_q)
            S_PLL_RST: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = S_WAIT_LOCK;
                    tmo_d   = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                tmo_d = tmo_q + 1'b1;
                if (timeout) begin
                    state_d = S_PLL_RST;
                    pulse_d = '0;
                end else if (locked_s) begin
                    state_d = S_FILTER;
                    flt_d   = '0;
                end
            end
            S_FILTER: begin
                // timeout wins over both a dropout and a completed filter
                tmo_d = tmo_q + 1'b1;
                if (timeout) begin
                    state_d = S_PLL_RST;
                    pulse_d = '0;
                end else if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (flt_q == FLT_LAST) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end else begin
                    flt_d = flt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    tmo_d   = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    tmo_d   = '0;
                    if (relock_q != '1) relock_d = relock_q + 1'b1;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                pulse_d = '0;
            end
        endcase
    end

    // outputs are decoded from the next state so they switch on the same edge as the state
    always_comb begin
        pll_rst_d   = (state_d == S_PLL_RST);
        sys_reset_d = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Table-driven bench for pll_lock_sequencer: each row holds locked for n edges and
// gives the outputs expected after each of those edges; expectations flow through a scoreboard.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int CNT_W = 2;

    logic             refclk = 1'b0;
    logic             rst_n  = 1'b0;
    logic             locked = 1'b0;
    logic             pll_rst;
    logic             sys_reset;
    logic             ready;
    logic [CNT_W-1:0] relock_count;

    always #10 refclk = ~refclk;

    pll_lock_sequencer #(
        .SYNC_STAGES  (2),
        .PLL_RST_PULSE(4),
        .LOCK_FILTER  (8),
        .RESET_HOLD   (4),
        .LOCK_TIMEOUT (64),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .relock_count(relock_count)
    );

    typedef struct {
        logic             lk;
        int               n;
        logic             pr;
        logic             sr;
        logic             rd;
        logic [CNT_W-1:0] rc;
    } vec_t;

    typedef struct {
        logic             pr;
        logic             sr;
        logic             rd;
        logic [CNT_W-1:0] rc;
        string            tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_no = 0;

    task automatic add(input logic lk, input int n, input logic pr, input logic sr,
                       input logic rd, input logic [CNT_W-1:0] rc);
        vec_t v;
        v.lk = lk; v.n = n; v.pr = pr; v.sr = sr; v.rd = rd; v.rc = rc;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input logic pr, input logic sr, input logic rd,
                            input logic [CNT_W-1:0] rc, input string tag);
        exp_t e;
        e.pr = pr; e.sr = sr; e.rd = rd; e.rc = rc; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry for DUT output");
            return;
        end
        e = sb.pop_front();
        if ({pll_rst, sys_reset, ready, relock_count} !== {e.pr, e.sr, e.rd, e.rc}) begin
            n_fail++;
            $display("FAIL %s: got pll_rst=%b sys_reset=%b ready=%b relock_count=%0d, expected pll_rst=%b sys_reset=%b ready=%b relock_count=%0d",
                     e.tag, pll_rst, sys_reset, ready, relock_count, e.pr, e.sr, e.rd, e.rc);
        end
    endtask

    task automatic run_tbl(input string name);
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                locked = tbl[i].lk;
                push_exp(tbl[i].pr, tbl[i].sr, tbl[i].rd, tbl[i].rc,
                         $sformatf("%s edge %0d", name, edge_no + 1));
                @(posedge refclk);
                #1;
                edge_no++;
                check();
            end
        end
        tbl.delete();
    endtask

    task automatic do_reset(input logic lk);
        rst_n  = 1'b0;
        locked = lk;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        rst_n   = 1'b1;
        edge_no = 0;
    endtask

    task automatic async_reset_check(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        push_exp(1'b1, 1'b1, 1'b0, '0, $sformatf("%s async reset", name));
        check();
    endtask

    task automatic powerup_seq(input string name);
        add(1, 3,  1, 1, 0, 0);
        add(1, 13, 0, 1, 0, 0);
        add(1, 5,  0, 0, 1, 0);
        run_tbl(name);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [CNT_W-1:0] rc_old, rc_new;

        // power-up with lock steady: RUN on edge 4+1+8+4 = 17
        do_reset(1'b1);
        push_exp(1'b1, 1'b1, 1'b0, '0, "reset values");
        check();
        powerup_seq("powerup");

        // permanent no-lock: 4-cycle pll_rst pulse every 68 cycles
        do_reset(1'b0);
        add(0, 3,  1, 1, 0, 0);
        add(0, 64, 0, 1, 0, 0);
        add(0, 4,  1, 1, 0, 0);
        add(0, 64, 0, 1, 0, 0);
        add(0, 4,  1, 1, 0, 0);
        run_tbl("no_lock");

        // one-cycle dropout during FILTER restarts the filter
        do_reset(1'b1);
        add(1, 3,  1, 1, 0, 0);
        add(1, 4,  0, 1, 0, 0);
        add(0, 1,  0, 1, 0, 0);
        add(1, 14, 0, 1, 0, 0);
        add(1, 3,  0, 0, 1, 0);
        run_tbl("glitch");

        // four 3-cycle lock losses in RUN; relock_count saturates at 3
        for (int k = 1; k <= 4; k++) begin
            rc_old = (k - 1 > 3) ? 2'd3 : CNT_W'(k - 1);
            rc_new = (k > 3) ? 2'd3 : CNT_W'(k);
            add(0, 2,  0, 0, 1, rc_old);
            add(0, 1,  0, 1, 0, rc_new);
            add(1, 14, 0, 1, 0, rc_new);
            add(1, 2,  0, 0, 1, rc_new);
            run_tbl($sformatf("relock%0d", k));
        end

        // async reset mid-HOLD (relock_count is 3 here), then clean restart
        add(0, 2,  0, 0, 1, 3);
        add(0, 1,  0, 1, 0, 3);
        add(1, 12, 0, 1, 0, 3);
        run_tbl("to_hold");
        async_reset_check("mid_hold");
        do_reset(1'b1);
        powerup_seq("restart_hold");

        // async reset mid-PLL_RST
        do_reset(1'b1);
        add(1, 2, 1, 1, 0, 0);
        run_tbl("to_pllrst");
        async_reset_check("mid_pllrst");
        do_reset(1'b1);
        powerup_seq("restart_pllrst");

        // locked_s first seen on the timeout edge 68: PLL_RST wins over FILTER
        do_reset(1'b0);
        add(0, 3,  1, 1, 0, 0);
        add(0, 62, 0, 1, 0, 0);
        add(1, 2,  0, 1, 0, 0);
        add(1, 4,  1, 1, 0, 0);
        add(1, 13, 0, 1, 0, 0);
        add(1, 2,  0, 0, 1, 0);
        run_tbl("timeout_race");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Supervisor for the PLL's `rst`/`locked` interface: drives the PLL reset input and consumes its `locked` output. Runs on the free-running 50 MHz reference clock, so it keeps working while the PLL is unlocked. Produces a clean, filtered core reset and a ready flag for the 20/40 MHz domains, re-sequences on lock loss, and pulses the PLL reset when lock is not achieved within a timeout.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `locked` (min 2).
- `PLL_RST_PULSE`, 16: cycles `pll_rst` is held high per PLL reset pulse (min 1).
- `LOCK_FILTER`, 1024: consecutive synchronized-high cycles of `locked` required.
- `RESET_HOLD`, 256: extra cycles `sys_reset` stays high after the filter passes.
- `LOCK_TIMEOUT`, 2500000: cycles allowed in WAIT_LOCK+FILTER before the PLL is reset again (50 ms).
- `CNT_W`, 8: width of `relock_count`.
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock output, asynchronous to `refclk`.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_reset` out 1: active-high core reset.
- `ready` out 1: high only in RUN.
- `relock_count` out CNT_W: number of lock losses seen in RUN; saturates.

## Operation
- `locked` passes through a SYNC_STAGES flop chain to give `locked_s`. Only `locked_s` is used internally.
- All outputs are registered. On reset: state PLL_RST, `pll_rst`=1, `sys_reset`=1, `ready`=0, `relock_count`=0, all counters 0, synchronizer 0.
- PLL_RST:
  - `pll_rst`=1.
  - After PLL_RST_PULSE cycles in this state, go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK:
  - Timeout counter increments each cycle.
  - `locked_s`=1 goes to FILTER and clears the filter counter.
- FILTER:
  - Timeout counter keeps incrementing; the filter counter increments while `locked_s`=1.
  - `locked_s`=0 returns to WAIT_LOCK. The timeout counter is not cleared.
  - After LOCK_FILTER consecutive high cycles, go to HOLD.
- Timeout:
  - In WAIT_LOCK or FILTER, when the timeout counter reaches LOCK_TIMEOUT-1, go to PLL_RST.
  - Timeout has priority over a simultaneous lock/filter transition.
- HOLD:
  - `sys_reset`=1.
  - After RESET_HOLD cycles, go to RUN.
  - `locked_s`=0 goes to WAIT_LOCK with the timeout counter cleared; `relock_count` is not incremented.
- RUN:
  - `sys_reset`=0, `ready`=1.
  - `locked_s`=0 goes to WAIT_LOCK: `sys_reset`=1 and `ready`=0 on the same edge, timeout counter cleared, `relock_count` incremented.
- `relock_count` saturates at 2^CNT_W-1.
- `sys_reset`=1 in every state except RUN; `pll_rst`=1 only in PLL_RST.
- Counter widths are sized by `$clog2` of their limits.
- Asserting `rst_n` at any time aborts immediately to the reset values, including mid-pulse or mid-HOLD.

## Timing
- `locked` to `locked_s` latency: SYNC_STAGES edges.
- From `rst_n` rising with `locked` steady high: `sys_reset` falls and `ready` rises on edge PLL_RST_PULSE + 1 + LOCK_FILTER + RESET_HOLD.
- Lock loss in RUN: `sys_reset` rises no later than SYNC_STAGES+1 edges after `locked` falls.
- `pll_rst` pulse width is exactly PLL_RST_PULSE cycles.
- Retry period under permanent no-lock: PLL_RST_PULSE + LOCK_TIMEOUT cycles.
- No glitches: every output is a flop output.

## Test plan
Parameters for all scenarios: PULSE=4, FILTER=8, HOLD=4, TIMEOUT=64, CNT_W=2.
- Power-up, `locked` held 1: `pll_rst`=1 for edges 1–4. `sys_reset` falls and `ready` rises on edge 17. `relock_count`=0.
- `locked` held 0: `pll_rst` pulses high for 4 cycles every 68 cycles. `sys_reset` stays 1 and `ready` stays 0 throughout.
- `locked` glitches low for 1 cycle during FILTER: the filter restarts. RUN is entered 8+4 cycles after the final rise (plus sync latency). No PLL reset occurs if the total stays under 64 cycles.
- In RUN, `locked` drops for 3 cycles: `sys_reset` rises within 3 edges and `relock_count`=1. `ready` returns FILTER+HOLD cycles after `locked_s` rises. After 4 such losses, `relock_count` saturates at 3.
- `rst_n` asserted mid-HOLD and mid-PLL_RST: all outputs return to reset values asynchronously. After release, the sequence restarts from edge 1 exactly as in scenario 1.
- `locked` rises on the same cycle the timeout expires: the block enters PLL_RST, not FILTER.
